// File: rtl/mvu_quantser.sv
// mvu_quantser: quantizer/serializer behind the MVU scaler.
// Each accepted N-lane vector is cut down to a qbw-bit window per lane that
// starts at bit msbidx. The window is written MSB-first as bit-transposed
// N-bit words into the data bank, one word per cycle.
`timescale 1ns/1ps

module mvu_quantser #(
  parameter int N        = 64,
  parameter int BSCALERP = 48,
  parameter int BQMSBIDX = 6,
  parameter int QBWOUTBD = 6,
  parameter int BDBANKA  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BQMSBIDX-1:0]     cfg_msbidx,
  input  logic [QBWOUTBD-1:0]     cfg_qbw,
  input  logic [BDBANKA-1:0]      cfg_baddr,
  input  logic                    in_valid,
  input  logic [N*BSCALERP-1:0]   in_data,
  output logic                    in_ready,
  output logic                    out_we,
  output logic [BDBANKA-1:0]      out_addr,
  output logic [N-1:0]            out_word,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [QBWOUTBD-1:0] QBW_MAX = QBWOUTBD'(BSCALERP);
  localparam logic [BQMSBIDX-1:0] MSB_MAX = BQMSBIDX'(BSCALERP - 1);

  typedef enum logic {IDLE, SER} state_t;

  state_t               state;
  logic [QBWOUTBD-1:0]  cnt;
  logic [QBWOUTBD-1:0]  qbw_r;
  logic [BQMSBIDX-1:0]  msbidx_r;
  logic [BDBANKA-1:0]   ptr;
  logic [N-1:0]         word_r;
  logic [BSCALERP-1:0]  lane_r [N];
  logic [BSCALERP-1:0]  in_sh  [N];
  logic [QBWOUTBD-1:0]  qbw_clamped;
  logic [BQMSBIDX-1:0]  msb_clamped;
  logic [BQMSBIDX-1:0]  sh_amt;
  logic                 last_k;
  logic                 accept;

  // Clamp incoming config so the latched window always fits inside a lane
  always_comb begin
    qbw_clamped = cfg_qbw;
    if (cfg_qbw == '0) begin
      qbw_clamped = QBWOUTBD'(1);
    end else if (cfg_qbw > QBW_MAX) begin
      qbw_clamped = QBW_MAX;
    end
    msb_clamped = (cfg_msbidx > MSB_MAX) ? MSB_MAX : cfg_msbidx;
  end

  // Final word of the vector; a zero qbw (only possible straight after reset) behaves as depth 1
  always_comb begin
    last_k = ({1'b0, cnt} + {{QBWOUTBD{1'b0}}, 1'b1}) >= {1'b0, qbw_r};
  end

  // Handshake depends only on registered state and start, never on in_data
  always_comb begin
    in_ready = !start && ((state == IDLE) || ((state == SER) && last_k));
    accept   = in_valid && in_ready;
  end

  // Left-align every lane so the selected MSB sits at the top bit; shifting
  // left one place per word then streams the window out with zero fill below bit 0
  always_comb begin
    sh_amt = MSB_MAX - msbidx_r;
    for (int i = 0; i < N; i++) begin
      in_sh[i] = in_data[i*BSCALERP +: BSCALERP] << sh_amt;
    end
  end

  // Main FSM: config latch, vector capture, per-word shift and pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      qbw_r    <= '0;
      msbidx_r <= '0;
      ptr      <= '0;
      word_r   <= '0;
      for (int i = 0; i < N; i++) begin
        lane_r[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            qbw_r    <= qbw_clamped;
            msbidx_r <= msb_clamped;
            ptr      <= cfg_baddr;
          end else if (accept) begin
            state <= SER;
            cnt   <= '0;
            for (int i = 0; i < N; i++) begin
              word_r[i] <= in_sh[i][BSCALERP-1];
              lane_r[i] <= in_sh[i] << 1;
            end
          end
        end
        SER: begin
          ptr <= ptr + BDBANKA'(1);
          if (last_k) begin
            if (accept) begin
              cnt <= '0;
              for (int i = 0; i < N; i++) begin
                word_r[i] <= in_sh[i][BSCALERP-1];
                lane_r[i] <= in_sh[i] << 1;
              end
            end else begin
              state  <= IDLE;
              word_r <= '0;
            end
          end else begin
            cnt <= cnt + QBWOUTBD'(1);
            for (int i = 0; i < N; i++) begin
              word_r[i] <= lane_r[i][BSCALERP-1];
              lane_r[i] <= lane_r[i] << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank port is decoded straight from registers so a reset drops out_we immediately
  always_comb begin
    out_we   = (state == SER);
    busy     = (state == SER);
    out_last = (state == SER) && last_k;
    out_addr = ptr;
    out_word = word_r;
  end

endmodule

// File: tb/tb_mvu_quantser.sv
// Self-checking bench for mvu_quantser: a queue-based write model plus
// directed literal checks and a randomized phase.
`timescale 1ns/1ps

module tb_mvu_quantser;

  localparam int N  = 64;
  localparam int BS = 48;
  localparam int BA = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [5:0]        cfg_msbidx;
  logic [5:0]        cfg_qbw;
  logic [BA-1:0]     cfg_baddr;
  logic              in_valid;
  logic [N*BS-1:0]   in_data;
  logic              in_ready;
  logic              out_we;
  logic [BA-1:0]     out_addr;
  logic [N-1:0]      out_word;
  logic              out_last;
  logic              busy;

  int comps = 0;
  int fails = 0;
  int cycle = 0;

  typedef struct {
    logic [BA-1:0] addr;
    logic [N-1:0]  word;
    logic          last;
  } wr_t;

  typedef struct {
    logic [BA-1:0] addr;
    logic [N-1:0]  word;
    logic          last;
    logic          ready;
    int            cyc;
  } log_t;

  wr_t  exp_q[$];
  log_t wlog[$];

  int            m_msb;
  int            m_qbw;
  logic [BA-1:0] m_ptr;

  mvu_quantser dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_msbidx(cfg_msbidx), .cfg_qbw(cfg_qbw), .cfg_baddr(cfg_baddr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_we(out_we), .out_addr(out_addr), .out_word(out_word),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: a vector becomes qbw queued writes; one write retires per clock
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_msb = 0;
      m_qbw = 0;
      m_ptr = '0;
    end else begin
      bit   rdy;
      bit   idle;
      rdy  = !start && (exp_q.size() <= 1);
      idle = (exp_q.size() == 0);
      if (!idle) void'(exp_q.pop_front());
      if (idle && start) begin
        m_qbw = (cfg_qbw == 0) ? 1 : ((int'(cfg_qbw) > BS) ? BS : int'(cfg_qbw));
        m_msb = (int'(cfg_msbidx) > BS - 1) ? BS - 1 : int'(cfg_msbidx);
        m_ptr = cfg_baddr;
      end
      if (in_valid && rdy) begin
        for (int k = 0; k < m_qbw; k++) begin
          wr_t w;
          w.word = '0;
          for (int i = 0; i < N; i++) begin
            int b;
            b = m_msb - k;
            if (b >= 0) w.word[i] = in_data[i*BS + b];
          end
          w.addr = m_ptr + BA'(k);
          w.last = (k == m_qbw - 1);
          exp_q.push_back(w);
        end
        m_ptr = m_ptr + BA'(m_qbw);
      end
    end
  end

  // Compare every cycle against the model and log the actual writes
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput("out_we", 64'(out_we), 64'd1);
      checkOutput("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
      checkOutput("out_word", out_word, exp_q[0].word);
      checkOutput("out_last", 64'(out_last), 64'(exp_q[0].last));
      checkOutput("busy", 64'(busy), 64'd1);
    end else begin
      checkOutput("out_we_idle", 64'(out_we), 64'd0);
      checkOutput("out_addr_idle", 64'(out_addr), 64'(m_ptr));
      checkOutput("out_word_idle", out_word, 64'd0);
      checkOutput("out_last_idle", 64'(out_last), 64'd0);
      checkOutput("busy_idle", 64'(busy), 64'd0);
    end
    checkOutput("in_ready", 64'(in_ready), 64'(!start && exp_q.size() <= 1));
    if (out_we) wlog.push_back('{addr: out_addr, word: out_word, last: out_last, ready: in_ready, cyc: cycle});
  end

  task automatic applyStimulus(input logic st, input logic [5:0] msb, input logic [5:0] qbw,
                               input logic [BA-1:0] baddr, input logic vld);
    start      = st;
    cfg_msbidx = msb;
    cfg_qbw    = qbw;
    cfg_baddr  = baddr;
    in_valid   = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) checkOutput("idle_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] msb, input logic [5:0] qbw, input logic [BA-1:0] baddr);
    wait_idle();
    applyStimulus(1'b1, msb, qbw, baddr, 1'b0);
    start = 1'b0;
  endtask

  task automatic send_vector(input bit hold);
    bit got;
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) begin ok = 1; break; end
    end
    if (!ok) checkOutput("accept_timeout", 64'd1, 64'd0);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [BS-1:0] v);
    in_data[i*BS +: BS] = v;
  endtask

  task automatic rand_data();
    for (int j = 0; j < N*BS/32; j++) in_data[j*32 +: 32] = $urandom();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_msbidx = '0; cfg_qbw = '0; cfg_baddr = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_we", 64'(out_we), 64'd0);
    checkOutput("rst_out_addr", 64'(out_addr), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    $display("[TB] basic run");
    do_start(6'd7, 6'd8, 15'h100);
    in_data = '0; set_lane(0, 48'hA5); set_lane(5, 48'hFF);
    wlog.delete();
    send_vector(0);
    wait_idle();
    checkOutput("basic_count", 64'(wlog.size()), 64'd8);
    if (wlog.size() == 8) begin
      logic [7:0] b0;
      b0 = 8'b1010_0101;
      for (int j = 0; j < 8; j++) begin
        checkOutput("basic_addr", 64'(wlog[j].addr), 64'(15'h100 + j));
        checkOutput("basic_bit0", 64'(wlog[j].word[0]), 64'(b0[7-j]));
        checkOutput("basic_bit5", 64'(wlog[j].word[5]), 64'd1);
        checkOutput("basic_last", 64'(wlog[j].last), 64'(j == 7));
        if (j > 0) checkOutput("basic_gap", 64'(wlog[j].cyc - wlog[j-1].cyc), 64'd1);
      end
    end

    $display("[TB] back-to-back");
    do_start(6'd47, 6'd2, 15'h0);
    wlog.delete();
    for (int v = 0; v < 3; v++) begin
      rand_data();
      send_vector(1);
    end
    in_valid = 1'b0;
    wait_idle();
    checkOutput("b2b_count", 64'(wlog.size()), 64'd6);
    if (wlog.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        checkOutput("b2b_addr", 64'(wlog[j].addr), 64'(j));
        checkOutput("b2b_ready", 64'(wlog[j].ready), 64'(j % 2 == 1));
        if (j > 0) checkOutput("b2b_gap", 64'(wlog[j].cyc - wlog[j-1].cyc), 64'd1);
      end
    end

    $display("[TB] zero pad");
    do_start(6'd1, 6'd4, 15'h10);
    in_data = '0; set_lane(0, 48'd3);
    wlog.delete();
    send_vector(0);
    wait_idle();
    checkOutput("pad_count", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      logic [3:0] pb;
      pb = 4'b1100;
      for (int j = 0; j < 4; j++) checkOutput("pad_bit0", 64'(wlog[j].word[0]), 64'(pb[3-j]));
    end

    $display("[TB] qbw zero clamp");
    do_start(6'd5, 6'd0, 15'h20);
    wlog.delete();
    rand_data(); send_vector(1);
    rand_data(); send_vector(0);
    wait_idle();
    checkOutput("qbw0_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      checkOutput("qbw0_addr1", 64'(wlog[1].addr), 64'h21);
      checkOutput("qbw0_last", 64'(wlog[0].last), 64'd1);
    end

    $display("[TB] wrap");
    do_start(6'd3, 6'd2, 15'h7FFF);
    wlog.delete();
    rand_data(); send_vector(0);
    wait_idle();
    checkOutput("wrap_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      checkOutput("wrap_addr0", 64'(wlog[0].addr), 64'h7FFF);
      checkOutput("wrap_addr1", 64'(wlog[1].addr), 64'h0000);
    end

    $display("[TB] start during SER");
    do_start(6'd7, 6'd8, 15'h300);
    wlog.delete();
    rand_data(); send_vector(0);
    applyStimulus(1'b0, 6'd7, 6'd8, 15'h300, 1'b0);
    applyStimulus(1'b1, 6'd7, 6'd8, 15'h200, 1'b0);
    start = 1'b0;
    wait_idle();
    checkOutput("ser_start_count", 64'(wlog.size()), 64'd8);
    if (wlog.size() == 8) checkOutput("ser_start_addr7", 64'(wlog[7].addr), 64'h307);

    $display("[TB] reset mid-vector");
    do_start(6'd7, 6'd8, 15'h500);
    rand_data(); send_vector(0);
    applyStimulus(1'b0, 6'd7, 6'd8, 15'h500, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_we", 64'(out_we), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("rst_word", out_word, 64'd0);
    checkOutput("rst_addr", 64'(out_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    do_start(6'd7, 6'd2, 15'h40);
    wlog.delete();
    rand_data(); send_vector(0);
    wait_idle();
    checkOutput("post_rst_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) checkOutput("post_rst_addr0", 64'(wlog[0].addr), 64'h40);

    $display("[TB] random phase");
    for (int c = 0; c < 600; c++) begin
      rand_data();
      applyStimulus(($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)),
                    6'($urandom_range(0, 63)), BA'($urandom()), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

endmodule
